// File: rtl/rf_defs.sv
// Shared definitions for the scoreboarded register file: encodings and slice helpers.
package rf_defs;

  localparam bit ZERO_REG_OFF = 1'b0;
  localparam bit ZERO_REG_ON  = 1'b1;
  localparam bit BYPASS_OFF   = 1'b0;
  localparam bit BYPASS_ON    = 1'b1;

  function automatic int unsigned num_regs(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // Low bit of slice k in a flattened port of k-indexed w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: stored value, optional same-cycle write forwarding, r0 masking, busy masking.
module rf_read_port
  import rf_defs::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NUM_WRITE = 2,
  parameter bit ZERO_REG  = ZERO_REG_ON,
  parameter bit BYPASS    = BYPASS_ON,
  parameter int NR        = 1 << AW
) (
  input  logic [AW-1:0]           rd_addr_i,
  input  logic [NR-1:0][DW-1:0]   mem_i,
  input  logic [NR-1:0]           busy_i,
  input  logic [NUM_WRITE-1:0]    wr_en_i,
  input  logic [NUM_WRITE*AW-1:0] wr_addr_i,
  input  logic [NUM_WRITE*DW-1:0] wr_data_i,
  output logic [DW-1:0]           rd_data_o,
  output logic                    rd_busy_o
);

  logic hit;

  always_comb begin
    hit       = 1'b0;
    rd_data_o = mem_i[rd_addr_i];
    // Ascending scan so the highest matching write port ends up forwarded.
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (BYPASS == BYPASS_ON && wr_en_i[j] &&
          wr_addr_i[slice_lo(j, AW) +: AW] == rd_addr_i) begin
        hit       = 1'b1;
        rd_data_o = wr_data_i[slice_lo(j, DW) +: DW];
      end
    end
    rd_busy_o = busy_i[rd_addr_i] & ~hit;
    if (ZERO_REG == ZERO_REG_ON && rd_addr_i == '0) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with destination scoreboard for decode-stage RAW stalls.
module register_file_sb
  import rf_defs::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 2,
  parameter bit ZERO_REG      = ZERO_REG_ON,
  parameter bit BYPASS        = BYPASS_ON
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic [NUM_WRITE-1:0]              wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
  input  logic                              rsv_en,
  input  logic [ADDRESS_WIDTH-1:0]          rsv_addr,
  output logic                              rsv_ready,
  output logic [(1<<ADDRESS_WIDTH)-1:0]     busy_vec,
  output logic                              err_unreserved
);

  localparam int NUM_REGS = num_regs(ADDRESS_WIDTH);
  localparam int AW       = ADDRESS_WIDTH;
  localparam int DW       = DATA_WIDTH;

  logic [NUM_REGS-1:0][DW-1:0] mem_q, mem_d;
  logic [NUM_REGS-1:0]         busy_q, busy_d;
  logic                        err_q, err_d;
  logic                        rsv_hit;

  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    rsv_hit = 1'b0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j]) begin
        if (!(ZERO_REG == ZERO_REG_ON && wr_addr[slice_lo(j, AW) +: AW] == '0)) begin
          mem_d[wr_addr[slice_lo(j, AW) +: AW]] = wr_data[slice_lo(j, DW) +: DW];
          if (!busy_q[wr_addr[slice_lo(j, AW) +: AW]]) err_d = 1'b1;
        end
        busy_d[wr_addr[slice_lo(j, AW) +: AW]] = 1'b0;
        if (wr_addr[slice_lo(j, AW) +: AW] == rsv_addr) rsv_hit = 1'b1;
      end
    end
    // A retiring producer frees the slot in the same cycle a new one claims it.
    rsv_ready = ~busy_q[rsv_addr] | rsv_hit |
                (ZERO_REG == ZERO_REG_ON && rsv_addr == '0);
    if (rsv_en && rsv_ready && !(ZERO_REG == ZERO_REG_ON && rsv_addr == '0))
      busy_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec       = busy_q;
  assign err_unreserved = err_q;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rp
    rf_read_port #(
      .DW(DW), .AW(AW), .NUM_WRITE(NUM_WRITE),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .NR(NUM_REGS)
    ) u_rp (
      .rd_addr_i (rd_addr[k*AW +: AW]),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[k*DW +: DW]),
      .rd_busy_o (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus random traffic against an array model.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra [4];
  logic        we [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [9:0]   rd_addr2;
  logic [19:0]  rd_addr4;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [63:0]  rd_data2;
  logic [127:0] rd_data4;
  logic [1:0]   rd_busy2;
  logic [3:0]   rd_busy4;
  logic         ready2, ready4, err2, err4;
  logic [31:0]  bv2, bv4;

  assign rd_addr2 = {ra[1], ra[0]};
  assign rd_addr4 = {ra[3], ra[2], ra[1], ra[0]};
  assign wr_en    = {we[1], we[0]};
  assign wr_addr  = {wa[1], wa[0]};
  assign wr_data  = {wd[1], wd[0]};

  always #5 clk = ~clk;

  register_file_sb #(.NUM_READ(2), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ready(ready2), .busy_vec(bv2), .err_unreserved(err2));

  register_file_sb #(.NUM_READ(4), .BYPASS(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_busy(rd_busy4),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ready(ready4), .busy_vec(bv4), .err_unreserved(err4));

  // Architectural model: plain register array and busy set.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_err;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit wr_match(input logic [4:0] a);
    return (we[0] && wa[0] == a) || (we[1] && wa[1] == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we[1] && wa[1] == a) return wd[1];
    if (byp && we[0] && wa[0] == a) return wd[0];
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a, input bit byp);
    return a != 0 && m_busy[a] && !(byp && wr_match(a));
  endfunction

  function automatic bit exp_ready();
    return rsv_addr == 0 || !m_busy[rsv_addr] || wr_match(rsv_addr);
  endfunction

  function automatic logic [31:0] model_bv();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    for (int k = 0; k < 4; k++) ra[k] = '0;
    for (int j = 0; j < 2; j++) begin
      we[j] = 1'b0; wa[j] = '0; wd[j] = '0;
    end
    rsv_en = 1'b0; rsv_addr = '0; rst = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered state.
  task automatic cycle();
    bit rdy;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rd_data_byp", rd_data2[k*32 +: 32], exp_data(ra[k], 1'b1));
      chk("rd_busy_byp", rd_busy2[k], exp_busy(ra[k], 1'b1));
    end
    for (int k = 0; k < 4; k++) begin
      chk("rd_data_nobyp", rd_data4[k*32 +: 32], exp_data(ra[k], 1'b0));
      chk("rd_busy_nobyp", rd_busy4[k], exp_busy(ra[k], 1'b0));
    end
    rdy = exp_ready();
    chk("rsv_ready", ready2, rdy);
    chk("rsv_ready4", ready4, rdy);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_err = 1'b0;
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j] != 0 && !m_busy[wa[j]]) m_err = 1'b1;
      for (int j = 0; j < 2; j++)
        if (we[j]) begin
          if (wa[j] != 0) m_mem[wa[j]] = wd[j];
          m_busy[wa[j]] = 1'b0;
        end
      if (rsv_en && rdy && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
    #1;
    chk("busy_vec", bv2, model_bv());
    chk("busy_vec4", bv4, model_bv());
    chk("err", err2, m_err);
    chk("err4", err4, m_err);
  endtask

  initial begin
    idle();
    rst = 1'b1; we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'hABCD;
    @(posedge clk); #1;
    model_reset();
    chk("reset_bv", bv2, 32'h0);
    chk("reset_err", err2, 1'b0);
    idle();

    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < 4; k++) ra[k] = a[4:0];
      rsv_addr = a[4:0];
      #1 chk("reset_rd", rd_data2[31:0], 32'h0);
      cycle();
    end
    idle();

    // Reserve r5, observe busy, then the producer writes back.
    rsv_en = 1'b1; rsv_addr = 5'd5; cycle();
    chk("bv5_set", bv2[5], 1'b1);
    idle(); ra[0] = 5'd5;
    #1 chk("rd_busy5", rd_busy2[0], 1'b1);
    cycle();
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    #1 chk("byp5_data", rd_data2[31:0], 32'hDEADBEEF);
    chk("byp5_busy", rd_busy2[0], 1'b0);
    chk("nobyp5_busy", rd_busy4[0], 1'b1);
    cycle();
    chk("bv5_clr", bv2[5], 1'b0);
    chk("err5", err2, 1'b0);

    // r7 busy: retry blocked, then accepted alongside the retiring write.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd7; cycle();
    #1 chk("rdy7_blocked", ready2, 1'b0);
    cycle();
    chk("bv7_hold", bv2[7], 1'b1);
    we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h77;
    #1 chk("rdy7_wr", ready2, 1'b1);
    cycle();
    chk("bv7_retake", bv2[7], 1'b1);
    chk("err7", err2, 1'b0);

    // Dual write to r9: higher port wins.
    idle(); ra[0] = 5'd9;
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h11;
    we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'h22;
    #1 chk("byp9", rd_data2[31:0], 32'h22);
    cycle();
    idle(); ra[0] = 5'd9;
    #1 chk("stored9", rd_data2[31:0], 32'h22);
    cycle();

    // r0 is hardwired.
    idle(); ra[0] = 5'd0; we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1 chk("r0_rd", rd_data2[31:0], 32'h0);
    chk("r0_rdy", ready2, 1'b1);
    cycle();
    chk("bv0", bv2[0], 1'b0);

    // Unreserved write to r3 pulses err for one cycle.
    idle(); we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h33; cycle();
    chk("err3_pulse", err2, 1'b1);
    idle(); cycle();
    chk("err3_drop", err2, 1'b0);

    // Reset mid-operation beats a same-cycle write.
    idle(); rsv_en = 1'b1; rsv_addr = 5'd4; cycle();
    idle(); rst = 1'b1; we[1] = 1'b1; wa[1] = 5'd4; wd[1] = 32'h44; cycle();
    chk("rst_bv", bv2, 32'h0);
    idle();
    for (int a = 0; a < 32; a += 4) begin
      for (int k = 0; k < 4; k++) ra[k] = 5'(a + k);
      cycle();
    end

    // Random traffic over a narrow address window to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        we[j] = 1'($urandom_range(0, 2) == 0);
        wa[j] = 5'($urandom_range(0, 15));
        wd[j] = $urandom;
      end
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 15));
      rst      = 1'($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
